// File: rtl/gcd_unit.sv
// gcd_unit: iterative subtraction-based Euclid GCD engine with valid/ready
// handshakes on both the operand and the result side. One subtract or
// compare step is performed per clock.
//
// Optional feature: define GCD_UNIT_CYCLE_COUNT_EN to add the iter_cnt port,
// an 8-bit saturating count of subtraction steps for the last/current job.

// Combinational two's-complement subtractor: diff = a - b, carry = (a >= b).
module gcd_sub #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             carry
);

  logic [WIDTH:0] sum;

  assign sum   = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
  assign diff  = sum[WIDTH-1:0];
  assign carry = sum[WIDTH];

endmodule

module gcd_unit #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef GCD_UNIT_CYCLE_COUNT_EN
  output logic [7:0]       iter_cnt,
`endif
  output logic [WIDTH-1:0] gcd_out
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t state;
  state_t next_state;

  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb;
  logic [WIDTH-1:0] res;

  logic [WIDTH-1:0] d;
  logic             c;
  logic [WIDTH-1:0] neg_d;
  logic             equal;
  logic             accept;
  logic             zero_pair;
  logic [WIDTH-1:0] or_pair;

  // ra - rb; the carry tells which operand is larger
  gcd_sub #(.WIDTH(WIDTH)) u_sub (
    .a     (ra),
    .b     (rb),
    .diff  (d),
    .carry (c)
  );

  // rb - ra is the two's-complement negation of the same difference
  assign neg_d     = ~d + {{(WIDTH-1){1'b0}}, 1'b1};
  assign equal     = c && (d == '0);
  assign accept    = in_valid && in_ready;
  assign zero_pair = (a_in == '0) || (b_in == '0);
  assign or_pair   = a_in | b_in;
  assign gcd_out   = res;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode: accept, finish on equal compare, release on result handshake
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (in_valid) next_state = CALC;
      CALC:    if (equal) next_state = DONE;
      DONE:    if (out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Handshake outputs decoded from the state register
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // Working registers; a pair containing a zero is loaded as (a|b, a|b) so it
  // finishes on the very first equal compare, giving the same one-step
  // latency as an equal-operand pair and leaving res = a|b
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ra  <= '0;
      rb  <= '0;
      res <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (zero_pair) begin
              ra <= or_pair;
              rb <= or_pair;
            end else begin
              ra <= a_in;
              rb <= b_in;
            end
          end
        end
        CALC: begin
          if (equal) begin
            res <= ra;
          end else if (c) begin
            ra <= d;
          end else begin
            rb <= neg_d;
          end
        end
        default: begin
          res <= res;
        end
      endcase
    end
  end

`ifdef GCD_UNIT_CYCLE_COUNT_EN
  // Step counter: cleared on accept, bumped on each real subtraction, saturating
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iter_cnt <= 8'd0;
    end else if (accept) begin
      iter_cnt <= 8'd0;
    end else if ((state == CALC) && !equal && (iter_cnt != 8'hFF)) begin
      iter_cnt <= iter_cnt + 8'd1;
    end
  end
`endif

endmodule
